mem_responder: RTL and testbench

- Multi-cycle data-memory responder: the target side of the CPU load/store interface (addr, data_in, data_out, master_enable, read_write, byte_enable).
- Replaces the zero-wait synchronous memory behind the MEM stage so the pipeline can be tested against realistic wait states.
- Accepts one request at a time, waits a programmable latency, then completes it with a one-cycle ready pulse; the pipeline stalls on !ready.
- Internal word-organised storage with byte-enable writes and an error flag for bad addresses.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 137 +++++++++++++
 tb/tb_mem_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Load/store bus between the CPU MEM stage (master) and a data-memory
// target (slave). The master holds every request field stable from the
// cycle master_enable rises until it sees the one-cycle ready pulse.
interface mem_responder_if;
    logic        master_enable;
    logic        read_write;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [3:0]  byte_enable;
    logic [31:0] data_out;
    logic        ready;
    logic        err;

    modport master (
        output master_enable, read_write, addr, data_in, byte_enable,
        input  data_out, ready, err
    );

    modport slave (
        input  master_enable, read_write, addr, data_in, byte_enable,
        output data_out, ready, err
    );
endinterface

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder. Accepts one request at a time, waits
// LATENCY cycles, executes it against internal word storage and signals
// completion with a registered one-cycle ready pulse (err for bad addresses).
module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        req_rw_q, req_rw_d;
    logic [31:0] req_data_q, req_data_d;
    logic [3:0]  req_be_q, req_be_d;
    logic [31:0] data_out_q, data_out_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        mem_we;

    // Storage powers up zeroed and is deliberately left untouched by reset,
    // so the pipeline can be reset without losing memory contents.
    logic [31:0] mem [DEPTH] = '{default: '0};

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_legal;

    // Decode the captured address: word index plus alignment/range legality.
    always_comb begin
        req_idx   = req_addr_q[DEPTH_LOG2+1:2];
        req_legal = (req_addr_q[1:0] == 2'b00) &&
                    ((req_addr_q >> (DEPTH_LOG2 + 2)) == 32'd0);
    end

    // Next-state logic: capture in IDLE, count down in WAIT, execute on the
    // edge into DONE, and return to IDLE regardless of master_enable.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_addr_d = req_addr_q;
        req_rw_d   = req_rw_q;
        req_data_d = req_data_q;
        req_be_d   = req_be_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.master_enable) begin
                    req_addr_d = bus.addr;
                    req_rw_d   = bus.read_write;
                    req_data_d = bus.data_in;
                    req_be_d   = bus.byte_enable;
                    cnt_d      = LOAD;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    if (!req_legal) begin
                        err_d      = 1'b1;
                        data_out_d = 32'd0;
                    end else if (req_rw_q) begin
                        data_out_d = mem[req_idx];
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            req_addr_q <= 32'd0;
            req_rw_q   <= 1'b0;
            req_data_q <= 32'd0;
            req_be_q   <= 4'd0;
            data_out_q <= 32'd0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
            req_rw_q   <= req_rw_d;
            req_data_q <= req_data_d;
            req_be_q   <= req_be_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    // Byte-lane write commit on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be_q[i]) begin
                    mem[req_idx][8*i +: 8] <= req_data_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.ready    = ready_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Requests push their hand-computed
// response (data, err, completion cycle) into a queue; a monitor pops and
// compares it whenever ready pulses.
module tb_mem_responder;

    localparam int LATENCY = 3;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        int          cycle;
    } resp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ready_seen = 0;
    resp_t exp_q[$];

    mem_responder_if bus();

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter used to check completion timing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                ready_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_ready: got ready=1 at cycle %0d expected none", cyc);
                end else begin
                    r = exp_q.pop_front();
                    check_output({r.name, "_cycle"}, 64'(cyc), 64'(r.cycle));
                    check_output({r.name, "_err"}, 64'(bus.err), 64'(r.err));
                    check_output({r.name, "_data"}, 64'(bus.data_out), 64'(r.data));
                end
            end
        end
    end

    task automatic wait_ready(input string name, input int n);
        int target;
        int k;
        target = ready_seen + n;
        k = 0;
        while (ready_seen < target && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (ready_seen < target) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got %0d pulses expected %0d", name, ready_seen, target);
        end
    endtask

    task automatic apply_stimulus(input string name, input logic rw, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] be,
                                  input logic [31:0] exp_data, input logic exp_err);
        resp_t r;
        @(negedge clk);
        #1;
        bus.master_enable = 1'b1;
        bus.read_write    = rw;
        bus.addr          = a;
        bus.data_in       = d;
        bus.byte_enable   = be;
        r.name  = name;
        r.data  = exp_data;
        r.err   = exp_err;
        r.cycle = cyc + 1 + LATENCY;
        exp_q.push_back(r);
        wait_ready(name, 1);
        bus.master_enable = 1'b0;
        bus.data_in       = 32'h0;
    endtask

    initial begin
        resp_t r;
        bus.master_enable = 1'b0;
        bus.read_write    = 1'b0;
        bus.addr          = 32'h0;
        bus.data_in       = 32'h0;
        bus.byte_enable   = 4'h0;

        // Reset for two cycles, then ten idle cycles with nothing happening.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check_output("idle_outputs", {30'd0, bus.ready, bus.err, bus.data_out}, 64'd0);
        end

        apply_stimulus("wr_full",      1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0,         1'b0);
        apply_stimulus("rd_full",      1'b1, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0);
        apply_stimulus("wr_bytes",     1'b0, 32'h0000_0010, 32'h1122_3344, 4'b0101, 32'hDEAD_BEEF, 1'b0);
        apply_stimulus("rd_bytes",     1'b1, 32'h0000_0010, 32'h0,         4'b1111, 32'hDE22_BE44, 1'b0);
        apply_stimulus("rd_range",     1'b1, 32'h0000_1000, 32'h0,         4'b1111, 32'h0,         1'b1);
        apply_stimulus("wr_misalign",  1'b0, 32'h0000_0012, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b1);
        apply_stimulus("rd_unchanged", 1'b1, 32'h0000_0010, 32'h0,         4'b0000, 32'hDE22_BE44, 1'b0);
        apply_stimulus("wr_be0",       1'b0, 32'h0000_0014, 32'hFFFF_FFFF, 4'b0000, 32'hDE22_BE44, 1'b0);
        apply_stimulus("rd_be0",       1'b1, 32'h0000_0014, 32'h0,         4'b0000, 32'h0,         1'b0);
        apply_stimulus("wr_top",       1'b0, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'b1111, 32'h0,         1'b0);
        apply_stimulus("rd_top",       1'b1, 32'h0000_0FFC, 32'h0,         4'b0000, 32'hA5A5_A5A5, 1'b0);
        apply_stimulus("rd_high",      1'b1, 32'h8000_0000, 32'h0,         4'b0000, 32'h0,         1'b1);

        // Held request: exactly two pulses, the second LATENCY+2 after the first.
        @(negedge clk);
        #1;
        bus.master_enable = 1'b1;
        bus.read_write    = 1'b1;
        bus.addr          = 32'h0000_0010;
        r.name = "held_first";  r.data = 32'hDE22_BE44; r.err = 1'b0; r.cycle = cyc + 1 + LATENCY;
        exp_q.push_back(r);
        r.name = "held_second"; r.data = 32'hDE22_BE44; r.err = 1'b0; r.cycle = cyc + 1 + 2*LATENCY + 2;
        exp_q.push_back(r);
        wait_ready("held", 2);
        bus.master_enable = 1'b0;

        // Reset during WAIT must abort the write without committing it.
        @(negedge clk);
        #1;
        bus.master_enable = 1'b1;
        bus.read_write    = 1'b0;
        bus.addr          = 32'h0000_0020;
        bus.data_in       = 32'hCAFE_F00D;
        bus.byte_enable   = 4'b1111;
        @(negedge clk);
        #1;
        reset = 1'b0;
        bus.master_enable = 1'b0;
        #1;
        check_output("reset_async", {30'd0, bus.ready, bus.err, bus.data_out}, 64'd0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (LATENCY + 2) @(negedge clk);
        #1;
        check_output("after_abort", {30'd0, bus.ready, bus.err, bus.data_out}, 64'd0);
        apply_stimulus("rd_aborted", 1'b1, 32'h0000_0020, 32'h0, 4'b1111, 32'h0, 1'b0);

        repeat (LATENCY + 4) @(negedge clk);
        check_output("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
